// File: rtl/sram_param.sv
// -----------------------------------------------------------------------------
// sram_param -- shared constants and types for the SRAM access arbiter.
//   SRAM_ADDR_COUNT : external SRAM address width (bits)
//   SRAM_DATA_WIDTH : external SRAM data width (bits)
//   WQ_DEPTH        : default number of loader write-queue entries (power of two)
//   ArbState        : arbiter FSM states (READ, WRITE, TURN)
// -----------------------------------------------------------------------------
package sram_param;

   localparam int SRAM_ADDR_COUNT = 20;
   localparam int SRAM_DATA_WIDTH = 16;
   localparam int WQ_DEPTH        = 4;

   typedef enum logic [1:0] {
      READ  = 2'd0,   // render port owns the SRAM, read cycle on the pins
      WRITE = 2'd1,   // one queued loader write per cycle
      TURN  = 2'd2    // bus turnaround: nobody drives dq
   } ArbState;

endpackage

// File: rtl/sram_write_queue.sv
// -----------------------------------------------------------------------------
// sram_write_queue -- synchronous FIFO holding loader writes (address + data)
// until the arbiter finds a blanking window to issue them.
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_push, i_push_addr/_data  enqueue (accepted when not full, or full with pop)
//   i_pop                      dequeue head (ignored when empty)
//   o_head_addr, o_head_data   current head entry
//   o_count                    number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sram_write_queue
   import sram_param::*;
#(
   parameter int DEPTH  = WQ_DEPTH,
   parameter int ADDR_W = SRAM_ADDR_COUNT,
   parameter int DATA_W = SRAM_DATA_WIDTH
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [ADDR_W-1:0]        i_push_addr,
   input  logic [DATA_W-1:0]        i_push_data,
   input  logic                     i_pop,
   output logic [ADDR_W-1:0]        o_head_addr,
   output logic [DATA_W-1:0]        o_head_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] r_addr_mem [DEPTH];
   logic [DATA_W-1:0] r_data_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = i_pop && !w_empty;
   // A pop in the same cycle frees the slot, so push at full is legal then.
   assign w_push  = i_push && (!w_full || w_pop);

   // NOTE: the storage array has no reset; count and pointers alone define
   // which entries are valid, so clearing the array would only add reset fan-out.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_addr_mem[r_wr_ptr] <= i_push_addr;
         r_data_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head_addr = r_addr_mem[r_rd_ptr];
   assign o_head_data = r_data_mem[r_rd_ptr];
   assign o_count     = r_count;

endmodule

// File: rtl/sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// sram_access_arbiter -- shares one asynchronous SRAM between a render read
// port (priority during the active display window) and a queued loader write
// port (drained during blanking). All SRAM pins are registered; pins lag the
// FSM state by one cycle.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_render_active                render port owns the SRAM
//   i_render_addr                  render read address (sampled every cycle)
//   o_render_data/_valid           read data, 2 cycles after its address
//   i_wr_valid/o_wr_ready          loader write handshake
//   i_wr_addr, i_wr_data           loader write payload
//   o_wq_count                     queued writes
//   o_sram_* / io_sram_dq          SRAM pins (active-low controls)
// -----------------------------------------------------------------------------
module sram_access_arbiter #(
   parameter int ADDR_W   = sram_param::SRAM_ADDR_COUNT,
   parameter int DATA_W   = sram_param::SRAM_DATA_WIDTH,
   parameter int WQ_DEPTH = sram_param::WQ_DEPTH
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_render_active,
   input  logic [ADDR_W-1:0]         i_render_addr,
   output logic [DATA_W-1:0]         o_render_data,
   output logic                      o_render_data_valid,
   input  logic                      i_wr_valid,
   output logic                      o_wr_ready,
   input  logic [ADDR_W-1:0]         i_wr_addr,
   input  logic [DATA_W-1:0]         i_wr_data,
   output logic [$clog2(WQ_DEPTH):0] o_wq_count,
   output logic [ADDR_W-1:0]         o_sram_addr,
   inout  wire  [DATA_W-1:0]         io_sram_dq,
   output logic                      o_sram_we_n,
   output logic                      o_sram_oe_n,
   output logic                      o_sram_ce_n,
   output logic                      o_sram_lb_n,
   output logic                      o_sram_ub_n
);

   import sram_param::*;

   localparam int CNT_W = $clog2(WQ_DEPTH) + 1;

   ArbState           r_state;
   ArbState           w_next_state;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0] w_head_data;
   logic [CNT_W-1:0]  w_wq_count;

   logic [ADDR_W-1:0] r_sram_addr;
   logic [DATA_W-1:0] r_sram_wdata;
   logic              r_we_n;
   logic              r_oe_n;
   logic              r_ce_n;
   logic              r_bytes_n;
   logic              r_dq_oe;
   logic              r_rd_phase;   // pins carry a read cycle this cycle
   logic [DATA_W-1:0] r_render_data;
   logic              r_render_valid;

   assign o_wr_ready = (w_wq_count < CNT_W'(WQ_DEPTH));
   assign w_push     = i_wr_valid && o_wr_ready;

   sram_write_queue #(
      .DEPTH  (WQ_DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_write_queue (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_push      (w_push),
      .i_push_addr (i_wr_addr),
      .i_push_data (i_wr_data),
      .i_pop       (w_pop),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_count     (w_wq_count)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= READ;
      else          r_state <= w_next_state;
   end

   // NOTE: every signal written here gets a default first, so no path
   // through the case leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_pop        = 1'b0;
      case (r_state)
         READ: begin
            if (!i_render_active && (w_wq_count != '0)) w_next_state = WRITE;
         end
         WRITE: begin
            w_pop = 1'b1;
            // Continue only if an entry remains behind the one popped now;
            // render demand ends the burst after the current write.
            if (!i_render_active && (w_wq_count > CNT_W'(1))) w_next_state = WRITE;
            else                                              w_next_state = TURN;
         end
         TURN:    w_next_state = READ;
         default: w_next_state = READ;
      endcase
   end

   // Pin registers: loaded from the current state, so the pins show that
   // state's bus cycle during the following clock period.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sram_addr    <= '0;
         r_sram_wdata   <= '0;
         r_we_n         <= 1'b1;
         r_oe_n         <= 1'b1;
         r_ce_n         <= 1'b1;
         r_bytes_n      <= 1'b1;
         r_dq_oe        <= 1'b0;
         r_rd_phase     <= 1'b0;
         r_render_data  <= '0;
         r_render_valid <= 1'b0;
      end else begin
         r_ce_n     <= 1'b0;
         r_bytes_n  <= 1'b0;
         r_rd_phase <= (r_state == READ);
         // Capture the read that was on the pins during the ending cycle.
         r_render_valid <= r_rd_phase;
         if (r_rd_phase) r_render_data <= io_sram_dq;
         case (r_state)
            READ: begin
               r_sram_addr <= i_render_addr;
               r_we_n      <= 1'b1;
               r_oe_n      <= 1'b0;
               r_dq_oe     <= 1'b0;
            end
            WRITE: begin
               r_sram_addr  <= w_head_addr;
               r_sram_wdata <= w_head_data;
               r_we_n       <= 1'b0;
               r_oe_n       <= 1'b1;
               r_dq_oe      <= 1'b1;
            end
            default: begin
               r_we_n  <= 1'b1;
               r_oe_n  <= 1'b1;
               r_dq_oe <= 1'b0;
            end
         endcase
      end
   end

   assign io_sram_dq          = r_dq_oe ? r_sram_wdata : {DATA_W{1'bz}};
   assign o_sram_addr         = r_sram_addr;
   assign o_sram_we_n         = r_we_n;
   assign o_sram_oe_n         = r_oe_n;
   assign o_sram_ce_n         = r_ce_n;
   assign o_sram_lb_n         = r_bytes_n;
   assign o_sram_ub_n         = r_bytes_n;
   assign o_render_data       = r_render_data;
   assign o_render_data_valid = r_render_valid;
   assign o_wq_count          = w_wq_count;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_access_arbiter -- directed bench for sram_access_arbiter with a
// behavioural asynchronous SRAM model. Inputs change and outputs are sampled
// 1 time unit after each rising edge (edges at 5, 15, 25, ...).
// -----------------------------------------------------------------------------
module tb_sram_access_arbiter;

   logic        clk;
   logic        rst_n;
   logic        render_active;
   logic [19:0] render_addr;
   logic [15:0] render_data;
   logic        render_valid;
   logic        wr_valid;
   logic        wr_ready;
   logic [19:0] wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  wq_count;
   logic [19:0] sram_addr;
   wire  [15:0] sram_dq;
   logic        we_n;
   logic        oe_n;
   logic        ce_n;
   logic        lb_n;
   logic        ub_n;

   int total = 0;
   int bad   = 0;
   int overlap = 0;

   typedef struct packed {
      logic [19:0] a;
      logic [15:0] d;
   } wr_t;
   wr_t wlog [$];

   // Behavioural SRAM: drives dq while selected for read, stores at mid-cycle
   // while we_n is low.
   logic [15:0] mem [4096] = '{'h10: 16'hA0A0, 'h11: 16'hA1A1, 'h12: 16'hA2A2, default: 16'h0000};
   logic        model_drive;
   assign model_drive = !ce_n && !oe_n && we_n;
   assign sram_dq     = model_drive ? mem[sram_addr[11:0]] : 16'hzzzz;

   always @(negedge clk) begin
      if (rst_n && dut.r_dq_oe && model_drive) overlap++;
      if (rst_n && !ce_n && !we_n) begin
         mem[sram_addr[11:0]] = sram_dq;
         wlog.push_back('{a: sram_addr, d: sram_dq});
      end
   end

   sram_access_arbiter dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_render_active     (render_active),
      .i_render_addr       (render_addr),
      .o_render_data       (render_data),
      .o_render_data_valid (render_valid),
      .i_wr_valid          (wr_valid),
      .o_wr_ready          (wr_ready),
      .i_wr_addr           (wr_addr),
      .i_wr_data           (wr_data),
      .o_wq_count          (wq_count),
      .o_sram_addr         (sram_addr),
      .io_sram_dq          (sram_dq),
      .o_sram_we_n         (we_n),
      .o_sram_oe_n         (oe_n),
      .o_sram_ce_n         (ce_n),
      .o_sram_lb_n         (lb_n),
      .o_sram_ub_n         (ub_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_wr(input int idx, input logic [19:0] a, input logic [15:0] d);
      wr_t e;
      e = (idx < wlog.size()) ? wlog[idx] : '0;
      check($sformatf("wlog[%0d].addr", idx), e.a, a);
      check($sformatf("wlog[%0d].data", idx), e.d, d);
   endtask

   initial begin
      rst_n         = 1'b0;
      render_active = 1'b0;
      render_addr   = '0;
      wr_valid      = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;

      // ---- reset values ----
      #12;
      check("rst.we_n", we_n, 1);
      check("rst.oe_n", oe_n, 1);
      check("rst.ce_n", ce_n, 1);
      check("rst.lb_n", lb_n, 1);
      check("rst.ub_n", ub_n, 1);
      check("rst.addr", sram_addr, 0);
      check("rst.rdata", render_data, 0);
      check("rst.valid", render_valid, 0);
      check("rst.count", wq_count, 0);
      check("rst.ready", wr_ready, 1);
      check("rst.dq_oe", dut.r_dq_oe, 0);
      rst_n = 1'b1;
      tick();                                        // t=16
      check("run.ce_n", ce_n, 0);
      check("run.lb_n", lb_n, 0);
      check("run.ub_n", ub_n, 0);

      // ---- render reads, 2-cycle latency ----
      render_active = 1'b1;
      render_addr   = 20'h00010;
      tick();                                        // t=26
      check("rd.addr", sram_addr, 20'h00010);
      check("rd.oe_n", oe_n, 0);
      check("rd.we_n", we_n, 1);
      render_addr = 20'h00011;
      tick();
      check("rd0.data", render_data, 16'hA0A0);
      check("rd0.valid", render_valid, 1);
      render_addr = 20'h00012;
      tick();
      check("rd1.data", render_data, 16'hA1A1);
      tick();                                        // t=56
      check("rd2.data", render_data, 16'hA2A2);
      check("rd2.valid", render_valid, 1);

      // ---- fill queue while displaying, then drain in blanking ----
      check("fill.ready0", wr_ready, 1);
      wr_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_addr = 20'h00100 + 20'(i);
         wr_data = 16'h1111 * 16'(i + 1);
         tick();
      end                                            // t=96
      wr_valid = 1'b0;
      check("fill.count", wq_count, 4);
      check("fill.ready", wr_ready, 0);
      wlog.delete();
      render_active = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();                                     // t=106 .. 166
         check($sformatf("drain%0d.we_n", i), we_n, (i >= 1 && i <= 4) ? 1'b0 : 1'b1);
         check($sformatf("drain%0d.oe_n", i), oe_n, (i == 0 || i == 6) ? 1'b0 : 1'b1);
         check($sformatf("drain%0d.count", i), wq_count, (i <= 4) ? 32'(4 - i) : 32'd0);
         if (i >= 1 && i <= 4) check($sformatf("drain%0d.addr", i), sram_addr, 20'h00100 + 20'(i - 1));
      end
      check("drain.nwrites", wlog.size(), 4);
      for (int i = 0; i < 4; i++) check_wr(i, 20'h00100 + 20'(i), 16'h1111 * 16'(i + 1));

      // ---- render preempts a write burst after its first write ----
      render_active = 1'b1;
      wr_valid      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_addr = 20'h00180 + 20'(i);
         wr_data = 16'h5555 + 16'h1111 * 16'(i);
         tick();
      end                                            // t=196
      wr_valid = 1'b0;
      check("pre.count", wq_count, 3);
      wlog.delete();
      render_active = 1'b0;
      tick();                                        // t=206, first WRITE cycle
      render_active = 1'b1;
      render_addr   = 20'h00010;
      tick();                                        // t=216
      check("pre.we_n", we_n, 0);
      check("pre.addr", sram_addr, 20'h00180);
      check("pre.count1", wq_count, 2);
      check("pre.valid0", render_valid, 1);
      tick();                                        // t=226, TURN pins
      check("pre.turn_we", we_n, 1);
      check("pre.turn_oe", oe_n, 1);
      check("pre.valid1", render_valid, 0);
      tick();                                        // t=236
      check("pre.read_oe", oe_n, 0);
      check("pre.valid2", render_valid, 0);
      check("pre.hold", render_data, 16'hA2A2);
      tick();                                        // t=246
      check("pre.valid3", render_valid, 1);
      check("pre.data3", render_data, 16'hA0A0);
      check("pre.nwrites", wlog.size(), 1);
      check("pre.count2", wq_count, 2);
      render_active = 1'b0;
      repeat (5) tick();                             // t=296
      check("rest.count", wq_count, 0);
      check("rest.nwrites", wlog.size(), 3);
      check_wr(0, 20'h00180, 16'h5555);
      check_wr(1, 20'h00181, 16'h6666);
      check_wr(2, 20'h00182, 16'h7777);

      // ---- full queue, loader keeps pushing while the queue drains ----
      render_active = 1'b1;
      wr_valid      = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wr_addr = 20'h001C0 + 20'(i);
         wr_data = 16'h8000 + 16'(i);
         tick();
      end                                            // t=336
      check("full.count", wq_count, 4);
      check("full.ready", wr_ready, 0);
      wr_addr = 20'h001C4;
      wr_data = 16'h8004;
      wlog.delete();
      render_active = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();                                     // t=346 .. 396
         check($sformatf("pp%0d.count", i), wq_count, (i == 0) ? 32'd4 : (i <= 2) ? 32'd3 : 32'(5 - i));
         if (i == 2) wr_valid = 1'b0;
      end
      repeat (2) tick();                             // t=416
      check("pp.nwrites", wlog.size(), 5);
      for (int i = 0; i < 5; i++) check_wr(i, 20'h001C0 + 20'(i), 16'h8000 + 16'(i));

      // ---- write then read back the same address ----
      wr_valid = 1'b1;
      wr_addr  = 20'h00200;
      wr_data  = 16'hBEEF;
      tick();                                        // t=426
      wr_valid    = 1'b0;
      render_addr = 20'h00200;
      repeat (5) tick();                             // t=476
      check("rb.data", render_data, 16'hBEEF);
      check("rb.valid", render_valid, 1);

      // ---- reset in the middle of a write burst ----
      render_active = 1'b1;
      wr_valid      = 1'b1;
      wr_addr       = 20'h00300;
      wr_data       = 16'h0A0A;
      tick();
      wr_addr = 20'h00301;
      wr_data = 16'h0B0B;
      tick();                                        // t=496
      wr_valid      = 1'b0;
      render_active = 1'b0;
      repeat (2) tick();                             // t=516
      check("mid.we_n", we_n, 0);
      check("mid.count", wq_count, 1);
      wlog.delete();
      #2 rst_n = 1'b0;                               // t=518, no clock edge
      #1;
      check("arst.we_n", we_n, 1);
      check("arst.oe_n", oe_n, 1);
      check("arst.dq_oe", dut.r_dq_oe, 0);
      check("arst.count", wq_count, 0);
      #3 rst_n = 1'b1;                               // t=522
      repeat (3) tick();                             // t=546
      check("post.count", wq_count, 0);
      check("post.we_n", we_n, 1);
      check("post.nwrites", wlog.size(), 0);

      check("dq_contention", overlap, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
